fmap_frame_buffer_streamer: RTL

//  Receiving end of the conv-layer output stream. Captures one full frame of NUM_CH

---
 rtl/fmap_frame_buffer_streamer_pkg.sv | 19 +
 rtl/fmap_frame_buffer_streamer_channel_ram.sv | 35 +++
 rtl/fmap_frame_buffer_streamer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fmap_frame_buffer_streamer_pkg.sv
// rtl/fmap_frame_buffer_streamer_pkg.sv - shared types and constants for the feature-map frame buffer
//
// Purpose: common definitions imported by the frame buffer top and its channel RAM.
//   FMAP_DATA_WIDTH : default width of one pixel word (fp32)
//   fp32_t          : one fp32 pixel word
//   fmap_state_t    : controller state encoding (IDLE=0, CAPTURE=1, DRAIN=2)
package fmap_frame_buffer_streamer_pkg;

    localparam int FMAP_DATA_WIDTH = 32;

    typedef logic [FMAP_DATA_WIDTH-1:0] fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } fmap_state_t;

endpackage

// File: rtl/fmap_frame_buffer_streamer_channel_ram.sv
// rtl/fmap_frame_buffer_streamer_channel_ram.sv - single-channel frame store, 1 write / 1 async read port
//
// Purpose: holds one channel of a captured frame, one word per pixel.
// Ports:
//   clk   : rising-edge clock for the write port
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// Contents are never reset; whatever is written (including X) is read back as-is.
module fmap_channel_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fmap_frame_buffer_streamer.sv
// rtl/fmap_frame_buffer_streamer.sv - captures one multi-channel frame and replays it with valid/ready
//
// Purpose: receives NUM_CH parallel conv-output channels, stores one full frame, then
// streams it back out in capture (raster) order as the source for the next layer.
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-high; wins over everything
//   valid_in     : input beat valid
//   data_in      : input beat, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_ready    : downstream accepts the current output beat
//   valid_out    : data_out holds a valid beat
//   data_out     : replayed beat, same channel packing as data_in
//   frame_stored : 1-cycle pulse after the last pixel of the frame is written
//   done         : 1-cycle pulse after the last pixel is accepted downstream
//   overflow     : sticky, set when valid_in arrives while draining
module fmap_frame_buffer_streamer
    import fmap_frame_buffer_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = FMAP_DATA_WIDTH,
    parameter int NUM_CH     = 8,
    parameter int IMG_WIDTH  = 20,
    parameter int IMG_HEIGHT = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         out_ready,
    output logic                         valid_out,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic                         frame_stored,
    output logic                         done,
    output logic                         overflow
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

    fmap_state_t                  state_q, state_d;
    logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    // Pointers never wrap, so "every address has been loaded" is kept as its own flag
    // instead of letting rd_ptr run past TOTAL-1.
    logic                         rd_all_q, rd_all_d;
    logic                         valid_out_q, valid_out_d;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                         frame_stored_q, frame_stored_d;
    logic                         done_q, done_d;
    logic                         overflow_q, overflow_d;

    logic                         wr_en;
    logic                         load;
    logic                         accept;
    logic [NUM_CH*DATA_WIDTH-1:0] rd_data;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            fmap_channel_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (TOTAL),
                .AW         (AW)
            ) u_ram (
                .clk   (clk),
                .we    (wr_en),
                .waddr (wr_ptr_q),
                .wdata (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
                .raddr (rd_ptr_q),
                .rdata (rd_data[c*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // The output register refills whenever it is empty or being emptied this cycle,
    // which sustains one beat per clock under continuous out_ready.
    assign load   = (state_q == ST_DRAIN) && !rd_all_q && (!valid_out_q || out_ready);
    assign accept = valid_out_q && out_ready;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        rd_all_d       = rd_all_q;
        valid_out_d    = valid_out_q;
        data_out_d     = data_out_q;
        frame_stored_d = 1'b0;
        done_d         = 1'b0;
        overflow_d     = overflow_q;
        wr_en          = 1'b0;

        case (state_q)
            ST_IDLE, ST_CAPTURE: begin
                if (valid_in) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d       = '0;
                        state_d        = ST_DRAIN;
                        frame_stored_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = ST_CAPTURE;
                    end
                end
            end
            ST_DRAIN: begin
                // Upstream has no backpressure, so a beat arriving now is lost.
                if (valid_in) begin
                    overflow_d = 1'b1;
                end
                if (load) begin
                    data_out_d  = rd_data;
                    valid_out_d = 1'b1;
                    if (rd_ptr_q == LAST_ADDR) begin
                        rd_all_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end else if (accept) begin
                    // Only reachable with nothing left to load: this is the final beat.
                    valid_out_d = 1'b0;
                    if (rd_all_q) begin
                        state_d  = ST_IDLE;
                        rd_ptr_d = '0;
                        rd_all_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            rd_all_q       <= 1'b0;
            valid_out_q    <= 1'b0;
            data_out_q     <= '0;
            frame_stored_q <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_all_q       <= rd_all_d;
            valid_out_q    <= valid_out_d;
            data_out_q     <= data_out_d;
            frame_stored_q <= frame_stored_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign frame_stored = frame_stored_q;
    assign done         = done_q;
    assign overflow     = overflow_q;

endmodule
